// File: rtl/ex_stage_pkg.sv
// Shared opcodes, FSM states and EX/MEM register layout for the execute stage.
package ex_stage_pkg;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_SUBI = 6'h03;
  localparam logic [5:0] OP_MUL  = 6'h04;
  localparam logic [5:0] OP_MULI = 6'h05;
  localparam logic [5:0] OP_OR   = 6'h06;
  localparam logic [5:0] OP_ORI  = 6'h07;
  localparam logic [5:0] OP_AND  = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h09;
  localparam logic [5:0] OP_XOR  = 6'h0A;
  localparam logic [5:0] OP_XORI = 6'h0B;
  localparam logic [5:0] OP_LDW  = 6'h0C;
  localparam logic [5:0] OP_STW  = 6'h0D;
  localparam logic [5:0] OP_BZ   = 6'h0E;
  localparam logic [5:0] OP_BEQ  = 6'h0F;
  localparam logic [5:0] OP_JR   = 6'h10;
  localparam logic [5:0] OP_HALT = 6'h11;

  typedef enum logic [1:0] {RUN, SQUASH, HALTED} ex_state_e;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [5:0]  rd_addr;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        valid;
  } ex_mem_t;

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU for the execute stage; signed-overflow flag only exists
// when EX_OVF_TRAP_EN is defined.
module ex_alu
  import ex_stage_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] imm,
`ifdef EX_OVF_TRAP_EN
  output logic        ovf,
`endif
  output logic [31:0] result
);

  logic [31:0] b_arith, sum, diff;

  // Odd opcodes in the arithmetic block take the immediate operand.
  assign b_arith = opcode[0] ? imm : rt_val;
  assign sum     = rs_val + b_arith;
  assign diff    = rs_val - b_arith;

  always_comb begin
    result = '0;
    case (opcode)
      OP_ADD, OP_ADDI: result = sum;
      OP_SUB, OP_SUBI: result = diff;
      OP_MUL:          result = rs_val * rt_val;
      OP_MULI:         result = rs_val * imm;
      OP_OR:           result = rs_val | rt_val;
      OP_ORI:          result = rs_val | imm;
      OP_AND:          result = rs_val & rt_val;
      OP_ANDI:         result = rs_val & imm;
      OP_XOR:          result = rs_val ^ rt_val;
      OP_XORI:         result = rs_val ^ imm;
      OP_LDW, OP_STW:  result = rs_val + imm;
      default:         result = '0;
    endcase
  end

`ifdef EX_OVF_TRAP_EN
  always_comb begin
    ovf = 1'b0;
    case (opcode)
      OP_ADD, OP_ADDI: ovf = (rs_val[31] == b_arith[31]) && (sum[31]  != rs_val[31]);
      OP_SUB, OP_SUBI: ovf = (rs_val[31] != b_arith[31]) && (diff[31] != rs_val[31]);
      default:         ovf = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch/JR resolution, wrong-path squash, sticky HALT,
// EX/MEM register. Define EX_OVF_TRAP_EN to add the overflow trap (ovf_2_if).
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int SQUASH_CNT = 2,
  parameter int BR_SHIFT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] pc4_in,
  input  logic [31:0] rs_val_in,
  input  logic [31:0] rt_val_in,
  input  logic [5:0]  rd_addr_in,
  input  logic [31:0] imm_in,
  input  logic        branch_in,
  input  logic        mem_read_in,
  input  logic        mem_to_reg_in,
  input  logic        mem_write_in,
  output logic [31:0] alu_result_2_mem,
  output logic [31:0] store_data_2_mem,
  output logic [5:0]  rd_addr_2_mem,
  output logic        reg_write_2_mem,
  output logic        mem_read_2_mem,
  output logic        mem_write_2_mem,
  output logic        mem_to_reg_2_mem,
  output logic        valid_2_mem,
`ifdef EX_OVF_TRAP_EN
  output logic        ovf_2_if,
`endif
  output logic        br_taken_2_if,
  output logic [31:0] br_target_2_if,
  output logic        halt_2_if
);

  ex_state_e   state, state_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic        run, is_ctrl, taken, alu_ovf;
  logic [31:0] alu_res, target;
  ex_mem_t     nxt, ex_mem_q;
  logic        br_taken_q;
  logic [31:0] br_target_q;
  logic        unused_pc4;

  // PC+4 travels with the decode bundle but no EX operation consumes it.
  assign unused_pc4 = ^pc4_in;

  ex_alu u_alu (
    .opcode (opcode_in),
    .rs_val (rs_val_in),
    .rt_val (rt_val_in),
    .imm    (imm_in),
`ifdef EX_OVF_TRAP_EN
    .ovf    (alu_ovf),
`endif
    .result (alu_res)
  );

`ifndef EX_OVF_TRAP_EN
  assign alu_ovf = 1'b0;
`endif

  assign run     = (state == RUN);
  assign is_ctrl = (opcode_in inside {OP_BZ, OP_BEQ, OP_JR, OP_HALT});
  assign target  = (opcode_in == OP_JR) ? rs_val_in : pc_in + (imm_in << BR_SHIFT);

  always_comb begin
    taken = 1'b0;
    if (run && branch_in) begin
      case (opcode_in)
        OP_BZ:   taken = (rs_val_in == '0);
        OP_BEQ:  taken = (rs_val_in == rt_val_in);
        OP_JR:   taken = 1'b1;
        default: taken = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (taken) begin
          state_nxt = SQUASH;
          cnt_nxt   = 2'(SQUASH_CNT);
        end else if (opcode_in == OP_HALT) begin
          state_nxt = HALTED;
        end
      end
      SQUASH: begin
        cnt_nxt = cnt - 2'd1;
        if (cnt == 2'd1) state_nxt = RUN;
      end
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Control instructions leave with valid set but every write enable cleared.
  always_comb begin
    nxt            = '0;
    nxt.alu_result = alu_res;
    nxt.store_data = (opcode_in == OP_STW) ? rt_val_in : '0;
    nxt.rd_addr    = rd_addr_in;
    nxt.mem_to_reg = mem_to_reg_in;
    nxt.reg_write  = (opcode_in <= OP_LDW) && (rd_addr_in != '0) && !alu_ovf;
    nxt.mem_read   = mem_read_in && !is_ctrl;
    nxt.mem_write  = mem_write_in && !is_ctrl;
    nxt.valid      = 1'b1;
    if (!run) begin
      nxt.valid     = 1'b0;
      nxt.reg_write = 1'b0;
      nxt.mem_read  = 1'b0;
      nxt.mem_write = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_mem_q    <= '0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
    end else begin
      ex_mem_q   <= nxt;
      br_taken_q <= taken;
      if (taken) br_target_q <= target;
    end
  end

`ifdef EX_OVF_TRAP_EN
  logic ovf_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              ovf_q <= 1'b0;
    else if (run && alu_ovf) ovf_q <= 1'b1;
  end
  assign ovf_2_if = ovf_q;
`endif

  assign alu_result_2_mem = ex_mem_q.alu_result;
  assign store_data_2_mem = ex_mem_q.store_data;
  assign rd_addr_2_mem    = ex_mem_q.rd_addr;
  assign reg_write_2_mem  = ex_mem_q.reg_write;
  assign mem_read_2_mem   = ex_mem_q.mem_read;
  assign mem_write_2_mem  = ex_mem_q.mem_write;
  assign mem_to_reg_2_mem = ex_mem_q.mem_to_reg;
  assign valid_2_mem      = ex_mem_q.valid;
  assign br_taken_2_if    = br_taken_q;
  assign br_target_2_if   = br_target_q;
  assign halt_2_if        = (state == HALTED);

endmodule

// File: tb/tb_ex_stage.sv
// Directed + randomized bench for ex_stage against a cycle-level reference model.
module tb_ex_stage;

  localparam int SQ = 2;
  localparam int SH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode_in, rd_addr_in;
  logic [31:0] pc_in, pc4_in, rs_val_in, rt_val_in, imm_in;
  logic        branch_in, mem_read_in, mem_to_reg_in, mem_write_in;
  logic [31:0] alu_result_2_mem, store_data_2_mem, br_target_2_if;
  logic [5:0]  rd_addr_2_mem;
  logic        reg_write_2_mem, mem_read_2_mem, mem_write_2_mem, mem_to_reg_2_mem;
  logic        valid_2_mem, br_taken_2_if, halt_2_if;
`ifdef EX_OVF_TRAP_EN
  logic        ovf_2_if;
`endif

  always #5 clk = ~clk;

  ex_stage #(.SQUASH_CNT(SQ), .BR_SHIFT(SH)) dut (
    .clk(clk), .reset(reset), .opcode_in(opcode_in), .pc_in(pc_in), .pc4_in(pc4_in),
    .rs_val_in(rs_val_in), .rt_val_in(rt_val_in), .rd_addr_in(rd_addr_in), .imm_in(imm_in),
    .branch_in(branch_in), .mem_read_in(mem_read_in), .mem_to_reg_in(mem_to_reg_in),
    .mem_write_in(mem_write_in), .alu_result_2_mem(alu_result_2_mem),
    .store_data_2_mem(store_data_2_mem), .rd_addr_2_mem(rd_addr_2_mem),
    .reg_write_2_mem(reg_write_2_mem), .mem_read_2_mem(mem_read_2_mem),
    .mem_write_2_mem(mem_write_2_mem), .mem_to_reg_2_mem(mem_to_reg_2_mem),
    .valid_2_mem(valid_2_mem),
`ifdef EX_OVF_TRAP_EN
    .ovf_2_if(ovf_2_if),
`endif
    .br_taken_2_if(br_taken_2_if), .br_target_2_if(br_target_2_if), .halt_2_if(halt_2_if)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state: remaining wrong-path slots, halt latch, last redirect.
  int          sq_left;
  bit          halted;
  logic [31:0] m_target;
  bit          m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] rs, rt, imm);
    case (op)
      6'h00: return rs + rt;
      6'h01: return rs + imm;
      6'h02: return rs - rt;
      6'h03: return rs - imm;
      6'h04: return 32'(64'(rs) * 64'(rt));
      6'h05: return 32'(64'(rs) * 64'(imm));
      6'h06: return rs | rt;
      6'h07: return rs | imm;
      6'h08: return rs & rt;
      6'h09: return rs & imm;
      6'h0A: return rs ^ rt;
      6'h0B: return rs ^ imm;
      6'h0C, 6'h0D: return rs + imm;
      default: return 32'h0;
    endcase
  endfunction

  // True signed result does not fit back into 32 bits.
  function automatic bit ref_ovf(input logic [5:0] op, input logic [31:0] rs, rt, imm);
    longint a, b, s;
    a = longint'($signed(rs));
    b = longint'($signed(op[0] ? imm : rt));
    case (op)
      6'h00, 6'h01: s = a + b;
      6'h02, 6'h03: s = a - b;
      default: return 1'b0;
    endcase
    return s != longint'($signed(s[31:0]));
  endfunction

  task automatic step(input logic [5:0] op, input logic [31:0] rs, rt, imm, pc,
                      input logic [5:0] rd);
    bit active, taken, exp_rw, ovf;
    logic [31:0] exp_alu, tgt;
    opcode_in = op; rs_val_in = rs; rt_val_in = rt; imm_in = imm; pc_in = pc;
    pc4_in = pc + 32'd4; rd_addr_in = rd;
    branch_in = (op == 6'h0E) || (op == 6'h0F) || (op == 6'h10);
    mem_read_in = (op == 6'h0C); mem_to_reg_in = (op == 6'h0C); mem_write_in = (op == 6'h0D);

    active  = !halted && (sq_left == 0);
    taken   = active && ((op == 6'h0E && rs == 0) || (op == 6'h0F && rs == rt) || op == 6'h10);
    tgt     = (op == 6'h10) ? rs : pc + (imm << SH);
    exp_alu = ref_alu(op, rs, rt, imm);
    exp_rw  = active && (op <= 6'h0C) && (rd != 0);
    ovf     = 1'b0;
`ifdef EX_OVF_TRAP_EN
    ovf = ref_ovf(op, rs, rt, imm);
    if (ovf) exp_rw = 1'b0;
    if (ovf && active) m_ovf = 1'b1;
`endif
    if (taken) begin
      m_target = tgt;
      sq_left  = SQ;
    end else if (sq_left > 0) begin
      sq_left--;
    end
    if (active && op == 6'h11) halted = 1'b1;

    @(posedge clk); #1;
    chk("valid", 32'(valid_2_mem), 32'(active));
    chk("reg_write", 32'(reg_write_2_mem), 32'(exp_rw));
    chk("mem_read", 32'(mem_read_2_mem), 32'(active && op == 6'h0C));
    chk("mem_write", 32'(mem_write_2_mem), 32'(active && op == 6'h0D));
    chk("br_taken", 32'(br_taken_2_if), 32'(taken));
    chk("br_target", br_target_2_if, m_target);
    chk("halt", 32'(halt_2_if), 32'(halted));
`ifdef EX_OVF_TRAP_EN
    chk("ovf", 32'(ovf_2_if), 32'(m_ovf));
`endif
    if (active) begin
      chk("alu_result", alu_result_2_mem, exp_alu);
      chk("rd_addr", 32'(rd_addr_2_mem), 32'(rd));
      chk("store_data", store_data_2_mem, (op == 6'h0D) ? rt : 32'h0);
      chk("mem_to_reg", 32'(mem_to_reg_2_mem), 32'(op == 6'h0C));
    end
  endtask

  // Assert reset between edges, check the asynchronous clear, release on negedge.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_alu", alu_result_2_mem, 32'h0);
    chk("rst_store", store_data_2_mem, 32'h0);
    chk("rst_rd", 32'(rd_addr_2_mem), 32'h0);
    chk("rst_ctl", 32'({reg_write_2_mem, mem_read_2_mem, mem_write_2_mem, mem_to_reg_2_mem}), 32'h0);
    chk("rst_valid", 32'(valid_2_mem), 32'h0);
    chk("rst_br", 32'(br_taken_2_if), 32'h0);
    chk("rst_target", br_target_2_if, 32'h0);
    chk("rst_halt", 32'(halt_2_if), 32'h0);
`ifdef EX_OVF_TRAP_EN
    chk("rst_ovf", 32'(ovf_2_if), 32'h0);
`endif
    sq_left = 0; halted = 1'b0; m_target = '0; m_ovf = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [5:0]  op, rd;
    logic [31:0] rs, rt, imm, pc;
    int          sel;
    reset = 1'b0;
    opcode_in = '0; rs_val_in = '0; rt_val_in = '0; imm_in = '0; pc_in = '0; pc4_in = '0;
    rd_addr_in = '0; branch_in = 1'b0; mem_read_in = 1'b0; mem_to_reg_in = 1'b0; mem_write_in = 1'b0;
    @(negedge clk);
    do_reset();

    step(6'h00, 32'd5, 32'd7, 32'h0, 32'h0, 6'd3);
    chk("add_5_7", alu_result_2_mem, 32'd12);
    step(6'h01, 32'd5, 32'd0, 32'h0, 32'h0, 6'd0);
    chk("rd0_no_write", 32'(reg_write_2_mem), 32'h0);
    step(6'h03, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'h0, 6'd4);
    chk("subi_neg1", alu_result_2_mem, 32'd1);

    step(6'h0F, 32'd9, 32'd9, 32'd4, 32'h100, 6'd0);
    chk("beq_target", br_target_2_if, 32'h110);
    chk("beq_pulse", 32'(br_taken_2_if), 32'h1);
    step(6'h00, 32'd1, 32'd1, 32'h0, 32'h104, 6'd1);
    chk("beq_pulse_end", 32'(br_taken_2_if), 32'h0);
    step(6'h00, 32'd1, 32'd2, 32'h0, 32'h108, 6'd2);
    step(6'h00, 32'd1, 32'd3, 32'h0, 32'h10C, 6'd3);
    chk("third_valid", 32'(valid_2_mem), 32'h1);

    step(6'h0E, 32'd1, 32'd0, 32'd8, 32'h200, 6'd0);
    chk("bz_not_taken", 32'(br_taken_2_if), 32'h0);
    step(6'h10, 32'h40, 32'd0, 32'h0, 32'h204, 6'd0);
    chk("jr_target", br_target_2_if, 32'h40);
    step(6'h00, 32'd1, 32'd1, 32'h0, 32'h0, 6'd1);
    step(6'h00, 32'd1, 32'd1, 32'h0, 32'h0, 6'd1);

    step(6'h0D, 32'h20, 32'hDEAD, 32'd8, 32'h300, 6'd0);
    chk("stw_addr", alu_result_2_mem, 32'h28);
    chk("stw_data", store_data_2_mem, 32'hDEAD);

    // HALT in the squash shadow must be ignored.
    step(6'h0E, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'h400, 6'd0);
    step(6'h11, 32'd0, 32'd0, 32'h0, 32'h0, 6'd0);
    step(6'h00, 32'd2, 32'd2, 32'h0, 32'h0, 6'd5);
    step(6'h00, 32'd2, 32'd2, 32'h0, 32'h0, 6'd5);
    chk("halt_squashed", 32'(halt_2_if), 32'h0);

    step(6'h11, 32'd0, 32'd0, 32'h0, 32'h0, 6'd0);
    step(6'h00, 32'd2, 32'd3, 32'h0, 32'h0, 6'd5);
    step(6'h0F, 32'd2, 32'd2, 32'h0, 32'h0, 6'd0);
    chk("halt_sticky", 32'(halt_2_if), 32'h1);
    do_reset();
    step(6'h00, 32'd2, 32'd3, 32'h0, 32'h0, 6'd5);
    chk("run_after_reset", 32'(valid_2_mem), 32'h1);

    step(6'h10, 32'h80, 32'd0, 32'h0, 32'h0, 6'd0);
    step(6'h00, 32'd1, 32'd1, 32'h0, 32'h0, 6'd1);
    do_reset();
    step(6'h00, 32'd4, 32'd4, 32'h0, 32'h0, 6'd7);

`ifdef EX_OVF_TRAP_EN
    step(6'h00, 32'h7FFF_FFFF, 32'd1, 32'h0, 32'h0, 6'd5);
    chk("ovf_no_write", 32'(reg_write_2_mem), 32'h0);
    chk("ovf_flag", 32'(ovf_2_if), 32'h1);
    do_reset();
`endif

    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 19);
      op  = (sel <= 17) ? 6'(sel) : 6'($urandom_range(18, 63));
      rs  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      rt  = ($urandom_range(0, 2) == 0) ? rs : $urandom;
      imm = $urandom_range(0, 1) ? $urandom : 32'(int'($urandom_range(0, 255)) - 128);
      pc  = $urandom & 32'hFFFF_FFFC;
      rd  = 6'($urandom_range(0, 63));
      step(op, rs, rt, imm, pc, rd);
      if ((halted && $urandom_range(0, 3) == 0) || (sq_left > 0 && $urandom_range(0, 15) == 0))
        do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
